// File: rtl/flash_axi_read_bridge_if.sv
// ---------------------------------------------------------------------------
// flash_axi_read_bridge_if
// AXI4 read-only bus bundle (AR + R channels) between a read master and the
// flash read bridge.
//   AR: arvalid/arready handshake, araddr, arid, arlen, arsize, arburst
//   R : rvalid/rready handshake, rdata (64b), rid, rresp, rlast
// Modports:
//   master - drives AR payload and rready, observes arready and R payload
//   slave  - the bridge side (mirror of master)
// ---------------------------------------------------------------------------
interface flash_axi_read_bridge_if #(
  parameter int ID_W = 4
);
  logic            arvalid;
  logic            arready;
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;

  logic            rvalid;
  logic            rready;
  logic [63:0]     rdata;
  logic [ID_W-1:0] rid;
  logic [1:0]      rresp;
  logic            rlast;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rid, rresp, rlast
  );
endinterface

// File: rtl/flash_axi_read_bridge.sv
// ---------------------------------------------------------------------------
// flash_axi_read_bridge
// AXI4 read-only slave in front of a flash model. Each AR burst is broken
// into single-beat flash reads; every beat costs ISSUE -> DATA -> RESP.
// Ports:
//   clock, reset  - sole clock, asynchronous active-high reset
//   axi           - AXI4 AR/R channels (slave modport)
//   flash_r_en    - one-cycle flash read strobe (high only during ISSUE)
//   flash_r_addr  - 8-byte aligned flash byte offset
//   flash_r_data  - flash word, valid the cycle after flash_r_en (DATA)
// Beats outside [FLASH_BASE, FLASH_BASE+FLASH_SIZE) return SLVERR with zero
// data and do not touch the flash.
// ---------------------------------------------------------------------------
module flash_axi_read_bridge #(
  parameter int          ID_W       = 4,
  parameter logic [31:0] FLASH_BASE = 32'h1000_0000,
  parameter logic [31:0] FLASH_SIZE = 32'h0040_0000
) (
  input  logic                    clock,
  input  logic                    reset,
  flash_axi_read_bridge_if.slave  axi,
  output logic                    flash_r_en,
  output logic [31:0]             flash_r_addr,
  input  logic [63:0]             flash_r_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      len_q, len_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;
  logic            in_range_q, in_range_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic [63:0]     rdata_q, rdata_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            rlast_q, rlast_d;
  logic            flash_r_en_q, flash_r_en_d;
  logic [31:0]     flash_r_addr_q, flash_r_addr_d;

  logic [31:0]     step_s;
  logic [31:0]     wrap_mask_s;
  logic [31:0]     next_addr_s;

  // Range check on the 8-byte aligned beat address; 33-bit compare so the
  // top of the window cannot overflow.
  function automatic logic in_flash(input logic [31:0] a);
    logic [32:0] al;
    al = {1'b0, a[31:3], 3'b000};
    return (al >= {1'b0, FLASH_BASE}) &&
           (al < ({1'b0, FLASH_BASE} + {1'b0, FLASH_SIZE}));
  endfunction

  function automatic logic [31:0] flash_off(input logic [31:0] a);
    logic [31:0] d;
    d = {a[31:3], 3'b000} - FLASH_BASE;
    return {d[31:3], 3'b000};
  endfunction

  // WRAP with an illegal length degrades to INCR; reserved 11 is INCR.
  function automatic logic [1:0] eff_burst(input logic [1:0] b, input logic [7:0] l);
    logic [1:0] r;
    case (b)
      BURST_FIXED: r = BURST_FIXED;
      BURST_WRAP:  r = ((l == 8'd1) || (l == 8'd3) || (l == 8'd7) || (l == 8'd15))
                       ? BURST_WRAP : BURST_INCR;
      default:     r = BURST_INCR;
    endcase
    return r;
  endfunction

  // Address of the following beat for the latched burst type.
  always_comb begin
    step_s      = 32'd1 << size_q;
    wrap_mask_s = (({24'd0, len_q} + 32'd1) << size_q) - 32'd1;
    case (burst_q)
      BURST_FIXED: next_addr_s = addr_q;
      BURST_WRAP:  next_addr_s = (addr_q & ~wrap_mask_s) | ((addr_q + step_s) & wrap_mask_s);
      default:     next_addr_s = addr_q + step_s;
    endcase
  end

  // FSM next-state and output computation. The flash strobe is scheduled on
  // the transition into ISSUE so it is high exactly during ISSUE and the
  // flash word is present during DATA.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    id_d           = id_q;
    len_d          = len_q;
    size_d         = size_q;
    burst_d        = burst_q;
    beat_cnt_d     = beat_cnt_q;
    in_range_d     = in_range_q;
    arready_d      = arready_q;
    rvalid_d       = rvalid_q;
    rdata_d        = rdata_q;
    rid_d          = rid_q;
    rresp_d        = rresp_q;
    rlast_d        = rlast_q;
    flash_r_en_d   = 1'b0;
    flash_r_addr_d = flash_r_addr_q;

    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (axi.arvalid && arready_q) begin
          arready_d    = 1'b0;
          addr_d       = axi.araddr;
          id_d         = axi.arid;
          len_d        = axi.arlen;
          size_d       = axi.arsize;
          burst_d      = eff_burst(axi.arburst, axi.arlen);
          beat_cnt_d   = 8'd0;
          in_range_d   = in_flash(axi.araddr);
          flash_r_en_d = in_flash(axi.araddr);
          if (in_flash(axi.araddr)) begin
            flash_r_addr_d = flash_off(axi.araddr);
          end else begin
            flash_r_addr_d = flash_r_addr_q;
          end
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = DATA;
      end
      DATA: begin
        if (in_range_q) begin
          rdata_d = flash_r_data;
          rresp_d = 2'b00;
        end else begin
          rdata_d = 64'd0;
          rresp_d = 2'b10;
        end
        rid_d    = id_q;
        rlast_d  = (beat_cnt_q == len_q);
        rvalid_d = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (rvalid_q && axi.rready) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            arready_d = 1'b1;
            state_d   = IDLE;
          end else begin
            beat_cnt_d   = beat_cnt_q + 8'd1;
            addr_d       = next_addr_s;
            in_range_d   = in_flash(next_addr_s);
            flash_r_en_d = in_flash(next_addr_s);
            if (in_flash(next_addr_s)) begin
              flash_r_addr_d = flash_off(next_addr_s);
            end else begin
              flash_r_addr_d = flash_r_addr_q;
            end
            state_d = ISSUE;
          end
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any burst in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= 32'd0;
      id_q           <= '0;
      len_q          <= 8'd0;
      size_q         <= 3'd0;
      burst_q        <= 2'b00;
      beat_cnt_q     <= 8'd0;
      in_range_q     <= 1'b0;
      arready_q      <= 1'b0;
      rvalid_q       <= 1'b0;
      rdata_q        <= 64'd0;
      rid_q          <= '0;
      rresp_q        <= 2'b00;
      rlast_q        <= 1'b0;
      flash_r_en_q   <= 1'b0;
      flash_r_addr_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      id_q           <= id_d;
      len_q          <= len_d;
      size_q         <= size_d;
      burst_q        <= burst_d;
      beat_cnt_q     <= beat_cnt_d;
      in_range_q     <= in_range_d;
      arready_q      <= arready_d;
      rvalid_q       <= rvalid_d;
      rdata_q        <= rdata_d;
      rid_q          <= rid_d;
      rresp_q        <= rresp_d;
      rlast_q        <= rlast_d;
      flash_r_en_q   <= flash_r_en_d;
      flash_r_addr_q <= flash_r_addr_d;
    end
  end

  assign axi.arready   = arready_q;
  assign axi.rvalid    = rvalid_q;
  assign axi.rdata     = rdata_q;
  assign axi.rid       = rid_q;
  assign axi.rresp     = rresp_q;
  assign axi.rlast     = rlast_q;
  assign flash_r_en    = flash_r_en_q;
  assign flash_r_addr  = flash_r_addr_q;

endmodule

// File: tb/tb_flash_axi_read_bridge.sv
// ---------------------------------------------------------------------------
// tb_flash_axi_read_bridge
// Directed bench for flash_axi_read_bridge with a behavioural flash model
// (one-cycle read latency) and a log of every flash read strobe.
// ---------------------------------------------------------------------------
module tb_flash_axi_read_bridge;
  localparam int ID_W = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flash_r_en;
  logic [31:0] flash_r_addr;
  logic [63:0] flash_r_data;

  flash_axi_read_bridge_if #(.ID_W(ID_W)) axi ();

  flash_axi_read_bridge #(
    .ID_W(ID_W),
    .FLASH_BASE(32'h1000_0000),
    .FLASH_SIZE(32'h0040_0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .axi(axi),
    .flash_r_en(flash_r_en),
    .flash_r_addr(flash_r_addr),
    .flash_r_data(flash_r_data)
  );

  always #5 clock = ~clock;

  // Flash content as a pure function of the aligned byte offset.
  function automatic logic [63:0] fword(input logic [31:0] off);
    if (off == 32'h0000_0010) return 64'h1122_3344_5566_7788;
    return {off ^ 32'hDEAD_BEEF, ~off};
  endfunction

  // Flash model: word appears the cycle after the strobe.
  always @(posedge clock) begin
    if (flash_r_en) flash_r_data <= fword(flash_r_addr);
  end

  int          en_total = 0;
  logic [31:0] log_addr [0:63];
  int          overlap = 0;
  int          en_in_reset = 0;

  // Strobe log.
  always @(posedge clock) begin
    if (flash_r_en) begin
      log_addr[en_total % 64] <= flash_r_addr;
      en_total <= en_total + 1;
    end
  end

  // Strobe must never coincide with a presented R beat or with reset.
  always @(negedge clock) begin
    if (flash_r_en && axi.rvalid) overlap <= overlap + 1;
    if (flash_r_en && reset) en_in_reset <= en_in_reset + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input string tag);
    bit ok;
    ok = 1'b0;
    axi.araddr  = addr;
    axi.arid    = id;
    axi.arlen   = len;
    axi.arsize  = size;
    axi.arburst = burst;
    axi.arvalid = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (axi.arready === 1'b1) ok = 1'b1;
      else tick();
    end
    tick();
    axi.arvalid = 1'b0;
    check({tag, " ar_accept"}, 64'(ok), 64'd1);
  endtask

  task automatic get_beat(input int stall, input logic [63:0] exp_data, input logic [1:0] exp_resp,
                          input logic exp_last, input logic [3:0] exp_id, input string tag);
    bit ok;
    ok = 1'b0;
    axi.rready = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (axi.rvalid === 1'b1) ok = 1'b1;
      else tick();
    end
    check({tag, " rvalid"}, 64'(ok), 64'd1);
    check({tag, " rdata"}, axi.rdata, exp_data);
    check({tag, " rresp"}, 64'(axi.rresp), 64'(exp_resp));
    check({tag, " rlast"}, 64'(axi.rlast), 64'(exp_last));
    check({tag, " rid"}, 64'(axi.rid), 64'(exp_id));
    for (int s = 0; s < stall; s++) begin
      tick();
      check({tag, " stall rvalid"}, 64'(axi.rvalid), 64'd1);
      check({tag, " stall rdata"}, axi.rdata, exp_data);
      check({tag, " stall rlast"}, 64'(axi.rlast), 64'(exp_last));
    end
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
  endtask

  initial begin
    int base;
    logic [31:0] exp_off [0:3];

    axi.arvalid = 1'b0;
    axi.araddr  = 32'd0;
    axi.arid    = 4'd0;
    axi.arlen   = 8'd0;
    axi.arsize  = 3'd0;
    axi.arburst = 2'b00;
    axi.rready  = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst arready", 64'(axi.arready), 64'd0);
    check("rst rvalid", 64'(axi.rvalid), 64'd0);
    check("rst rdata", axi.rdata, 64'd0);
    check("rst flash_r_en", 64'(flash_r_en), 64'd0);
    check("rst flash_r_addr", 64'(flash_r_addr), 64'd0);
    reset = 1'b0;
    check("post-rst arready low", 64'(axi.arready), 64'd0);
    tick();
    check("post-rst arready high", 64'(axi.arready), 64'd1);

    // Single 8-byte read
    base = en_total;
    drive_ar(32'h1000_0010, 4'd5, 8'd0, 3'd3, 2'b01, "single");
    get_beat(0, 64'h1122_3344_5566_7788, 2'b00, 1'b1, 4'd5, "single");
    check("single en count", 64'(en_total - base), 64'd1);
    check("single flash addr", 64'(log_addr[base % 64]), 64'h10);

    // INCR x4 with beat 1 stalled 5 cycles
    base = en_total;
    drive_ar(32'h1000_0000, 4'd7, 8'd3, 3'd3, 2'b01, "incr");
    get_beat(0, fword(32'h00), 2'b00, 1'b0, 4'd7, "incr b0");
    get_beat(5, fword(32'h08), 2'b00, 1'b0, 4'd7, "incr b1");
    get_beat(0, fword(32'h10), 2'b00, 1'b0, 4'd7, "incr b2");
    get_beat(0, fword(32'h18), 2'b00, 1'b1, 4'd7, "incr b3");
    check("incr en count", 64'(en_total - base), 64'd4);
    check("incr addr0", 64'(log_addr[(base + 0) % 64]), 64'h00);
    check("incr addr1", 64'(log_addr[(base + 1) % 64]), 64'h08);
    check("incr addr2", 64'(log_addr[(base + 2) % 64]), 64'h10);
    check("incr addr3", 64'(log_addr[(base + 3) % 64]), 64'h18);

    // WRAP x4 starting mid-window
    base = en_total;
    exp_off[0] = 32'h30; exp_off[1] = 32'h38; exp_off[2] = 32'h20; exp_off[3] = 32'h28;
    drive_ar(32'h1000_0030, 4'd1, 8'd3, 3'd3, 2'b10, "wrap");
    for (int i = 0; i < 4; i++) begin
      get_beat(0, fword(exp_off[i]), 2'b00, (i == 3), 4'd1, "wrap");
      check("wrap flash addr", 64'(log_addr[(base + i) % 64]), 64'(exp_off[i]));
    end

    // Below the window: SLVERR then OKAY
    base = en_total;
    drive_ar(32'h0FFF_FFF8, 4'd2, 8'd1, 3'd3, 2'b01, "low");
    get_beat(0, 64'd0, 2'b10, 1'b0, 4'd2, "low b0");
    get_beat(0, fword(32'h0), 2'b00, 1'b1, 4'd2, "low b1");
    check("low en count", 64'(en_total - base), 64'd1);
    check("low flash addr", 64'(log_addr[base % 64]), 64'h0);

    // First byte past the top
    base = en_total;
    drive_ar(32'h1040_0000, 4'd3, 8'd0, 3'd3, 2'b01, "top");
    get_beat(0, 64'd0, 2'b10, 1'b1, 4'd3, "top");
    check("top en count", 64'(en_total - base), 64'd0);

    // Burst crossing the top: OKAY then SLVERR
    base = en_total;
    drive_ar(32'h103F_FFF8, 4'd4, 8'd1, 3'd3, 2'b01, "cross");
    get_beat(0, fword(32'h003F_FFF8), 2'b00, 1'b0, 4'd4, "cross b0");
    get_beat(0, 64'd0, 2'b10, 1'b1, 4'd4, "cross b1");
    check("cross en count", 64'(en_total - base), 64'd1);

    // Reset in RESP of beat 1 of 4
    drive_ar(32'h1000_0000, 4'd2, 8'd3, 3'd3, 2'b01, "abort");
    get_beat(0, fword(32'h00), 2'b00, 1'b0, 4'd2, "abort b0");
    begin
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
        if (axi.rvalid === 1'b1) ok = 1'b1;
        else tick();
      end
      check("abort b1 rvalid", 64'(ok), 64'd1);
    end
    reset = 1'b1;
    #1;
    check("abort rvalid", 64'(axi.rvalid), 64'd0);
    check("abort rdata", axi.rdata, 64'd0);
    check("abort rlast", 64'(axi.rlast), 64'd0);
    check("abort rid", 64'(axi.rid), 64'd0);
    check("abort arready", 64'(axi.arready), 64'd0);
    check("abort flash_r_en", 64'(flash_r_en), 64'd0);
    check("abort flash_r_addr", 64'(flash_r_addr), 64'd0);
    base = en_total;
    tick();
    tick();
    tick();
    reset = 1'b0;
    check("abort no strobes in reset", 64'(en_total - base), 64'd0);
    drive_ar(32'h1000_0040, 4'd9, 8'd0, 3'd3, 2'b01, "after");
    get_beat(0, fword(32'h40), 2'b00, 1'b1, 4'd9, "after");
    for (int k = 0; k < 6; k++) tick();
    check("after no stale beat", 64'(axi.rvalid), 64'd0);
    check("after en count", 64'(en_total - base), 64'd1);
    check("after flash addr", 64'(log_addr[base % 64]), 64'h40);

    // Back-to-back: narrow INCR then a queued request
    base = en_total;
    exp_off[0] = 32'h0; exp_off[1] = 32'h0; exp_off[2] = 32'h8; exp_off[3] = 32'h8;
    drive_ar(32'h1000_0000, 4'd1, 8'd3, 3'd2, 2'b01, "b2b");
    axi.araddr  = 32'h1000_0100;
    axi.arid    = 4'd3;
    axi.arlen   = 8'd0;
    axi.arsize  = 3'd3;
    axi.arburst = 2'b01;
    axi.arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("b2b arready held low", 64'(axi.arready), 64'd0);
      get_beat(0, fword(exp_off[i]), 2'b00, (i == 3), 4'd1, "b2b");
      check("b2b flash addr", 64'(log_addr[(base + i) % 64]), 64'(exp_off[i]));
    end
    check("b2b arready after rlast", 64'(axi.arready), 64'd1);
    tick();
    axi.arvalid = 1'b0;
    check("b2b second accepted", 64'(axi.arready), 64'd0);
    get_beat(0, fword(32'h100), 2'b00, 1'b1, 4'd3, "b2b second");
    check("b2b en count", 64'(en_total - base), 64'd5);

    check("strobe during rvalid", 64'(overlap), 64'd0);
    check("strobe during reset", 64'(en_in_reset), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
